// File: rtl/rx_tag_demultiplexer.sv
// Receive-side tag manager: hands out free external PCIe tags for TX read requests,
// then steers returning completion beats to the owning channel/stream and recycles tags.

`ifndef SIG_TAG_W
`define SIG_TAG_W 8
`endif
`ifndef SIG_LEN_W
`define SIG_LEN_W 10
`endif
`ifndef SIG_BYTECNT_W
`define SIG_BYTECNT_W 12
`endif

module rx_tag_demultiplexer #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_NUM_CHNL       = 12,
  parameter int C_TAG_WIDTH      = 5
) (
  input  logic                            CLK,
  input  logic                            RST_IN,
  input  logic [5:0]                      INT_TAG,
  input  logic                            INT_TAG_VALID,
  output logic [C_TAG_WIDTH-1:0]          EXT_TAG,
  output logic                            EXT_TAG_VALID,
  output logic                            RXBUF_SPACE_AVAIL,
  input  logic [C_PCI_DATA_WIDTH-1:0]     RXC_DATA,
  input  logic                            RXC_DATA_VALID,
  input  logic [C_PCI_DATA_WIDTH/32-1:0]  RXC_DATA_WORD_ENABLE,
  input  logic                            RXC_DATA_START_FLAG,
  input  logic                            RXC_DATA_END_FLAG,
  input  logic [`SIG_TAG_W-1:0]           RXC_META_TAG,
  input  logic [`SIG_LEN_W-1:0]           RXC_META_LENGTH,
  input  logic [`SIG_BYTECNT_W-1:0]       RXC_META_BYTES_REMAINING,
  output logic [C_PCI_DATA_WIDTH-1:0]     CHNL_DATA,
  output logic [C_PCI_DATA_WIDTH/32-1:0]  CHNL_DATA_EN,
  output logic [C_NUM_CHNL-1:0]           CHNL_MAIN_VALID,
  output logic [C_NUM_CHNL-1:0]           CHNL_SG_RX_VALID,
  output logic [C_NUM_CHNL-1:0]           CHNL_SG_TX_VALID,
  output logic [C_NUM_CHNL-1:0]           CHNL_REQ_DONE,
  output logic                            TAG_ERR
);

  localparam int NUM_TAGS = 2**C_TAG_WIDTH;
  localparam int CW       = C_TAG_WIDTH + 1;

  logic [NUM_TAGS-1:0]    free_map;
  logic [NUM_TAGS-1:0]    masked_map;
  logic [CW-1:0]          free_cnt;
  logic [CW-1:0]          free_cnt_next;
  logic [C_TAG_WIDTH-1:0] next_tag;
  logic                   next_ok;
  logic [C_TAG_WIDTH-1:0] lowest_tag;
  logic                   lowest_ok;
  logic [5:0]             tag_table [NUM_TAGS];
  logic                   alloc;

  logic [C_TAG_WIDTH-1:0] lookup_tag;
  logic                   start_final;
  logic [C_TAG_WIDTH-1:0] pkt_tag;
  logic [5:0]             pkt_entry;
  logic                   pkt_used;
  logic                   pkt_final;
  logic [C_TAG_WIDTH-1:0] cur_tag;
  logic [5:0]             cur_entry;
  logic                   cur_used;
  logic                   cur_final;
  logic [3:0]             cur_chnl;
  logic [1:0]             cur_stream;
  logic                   route_ok;
  logic                   beat_ok;
  logic                   do_free;
  logic                   err_now;
  logic [C_NUM_CHNL-1:0]  chnl_onehot;
  logic                   unused_tag_bits;

  assign unused_tag_bits = ^RXC_META_TAG[`SIG_TAG_W-1:C_TAG_WIDTH];
  assign lookup_tag      = RXC_META_TAG[C_TAG_WIDTH-1:0];
  assign alloc           = INT_TAG_VALID && next_ok && (free_cnt != '0);
  assign start_final     = 32'(RXC_META_BYTES_REMAINING) <= (32'(RXC_META_LENGTH) << 2);

  // The tag handed out this cycle must not be offered again next cycle.
  always_comb begin
    masked_map = free_map;
    if (alloc)
      masked_map[next_tag] = 1'b0;
    lowest_tag = '0;
    lowest_ok  = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (masked_map[i]) begin
        lowest_tag = C_TAG_WIDTH'(i);
        lowest_ok  = 1'b1;
      end
    end
  end

  // The START beat routes from the live table lookup; later beats use the latched context.
  always_comb begin
    if (RXC_DATA_START_FLAG) begin
      cur_tag   = lookup_tag;
      cur_entry = tag_table[lookup_tag];
      cur_used  = !free_map[lookup_tag];
      cur_final = start_final;
    end else begin
      cur_tag   = pkt_tag;
      cur_entry = pkt_entry;
      cur_used  = pkt_used;
      cur_final = pkt_final;
    end
    cur_chnl    = cur_entry[5:2];
    cur_stream  = cur_entry[1:0];
    route_ok    = (cur_stream != 2'd3) && (32'(cur_chnl) < C_NUM_CHNL);
    beat_ok     = RXC_DATA_VALID && cur_used && route_ok;
    do_free     = RXC_DATA_VALID && RXC_DATA_END_FLAG && cur_used && cur_final;
    chnl_onehot = route_ok ? (C_NUM_CHNL'(1) << cur_chnl) : '0;
    err_now     = (INT_TAG_VALID && (free_cnt == '0)) ||
                  (RXC_DATA_VALID && !(cur_used && route_ok));
    free_cnt_next = free_cnt + CW'(do_free) - CW'(alloc);
  end

  always_ff @(posedge CLK) begin
    if (alloc)
      tag_table[next_tag] <= INT_TAG;
  end

  always_ff @(posedge CLK or posedge RST_IN) begin
    if (RST_IN) begin
      free_map          <= '1;
      free_cnt          <= CW'(NUM_TAGS);
      next_tag          <= '0;
      next_ok           <= 1'b1;
      EXT_TAG           <= '0;
      EXT_TAG_VALID     <= 1'b0;
      RXBUF_SPACE_AVAIL <= 1'b0;
      TAG_ERR           <= 1'b0;
      pkt_tag           <= '0;
      pkt_entry         <= '0;
      pkt_used          <= 1'b0;
      pkt_final         <= 1'b0;
    end else begin
      if (alloc)
        free_map[next_tag] <= 1'b0;
      if (do_free)
        free_map[cur_tag] <= 1'b1;
      free_cnt          <= free_cnt_next;
      next_tag          <= lowest_tag;
      next_ok           <= lowest_ok;
      EXT_TAG_VALID     <= alloc;
      if (alloc)
        EXT_TAG <= next_tag;
      RXBUF_SPACE_AVAIL <= free_cnt_next >= CW'(2);
      TAG_ERR           <= TAG_ERR | err_now;
      if (RXC_DATA_VALID && RXC_DATA_START_FLAG) begin
        pkt_tag   <= lookup_tag;
        pkt_entry <= tag_table[lookup_tag];
        pkt_used  <= !free_map[lookup_tag];
        pkt_final <= start_final;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST_IN) begin
    if (RST_IN) begin
      CHNL_DATA        <= '0;
      CHNL_DATA_EN     <= '0;
      CHNL_MAIN_VALID  <= '0;
      CHNL_SG_RX_VALID <= '0;
      CHNL_SG_TX_VALID <= '0;
      CHNL_REQ_DONE    <= '0;
    end else begin
      if (RXC_DATA_VALID)
        CHNL_DATA <= RXC_DATA;
      CHNL_DATA_EN     <= RXC_DATA_VALID ? RXC_DATA_WORD_ENABLE : '0;
      CHNL_MAIN_VALID  <= (beat_ok && cur_stream == 2'd0) ? chnl_onehot : '0;
      CHNL_SG_RX_VALID <= (beat_ok && cur_stream == 2'd1) ? chnl_onehot : '0;
      CHNL_SG_TX_VALID <= (beat_ok && cur_stream == 2'd2) ? chnl_onehot : '0;
      CHNL_REQ_DONE    <= (beat_ok && do_free) ? chnl_onehot : '0;
    end
  end

endmodule
